spi_xfer_sched: RTL
===================

// Module: spi_xfer_sched
// PURPOSE
//  Shares one spi_master core (8-bit, CPOL/CPHA/prescaler set by its owner) between NREQ requesters.
//  Arbitrates round-robin, owns per-requester slave selects and streams multi-byte bursts.
//  Per byte: load datai, pulse go, wait done, return datao to the burst owner.
//  Sits between requesting engines (flash reader, DMA, CPU port) and the core; no bus interface.
// PARAMETERS
//  NREQ      2  number of requesters (2..8)
//  DW        8  SPI word width; equals the core's DATA_WIDTH
//  LENW      4  burst length field width; burst = req_len+1 words (1..16)
//  CS_SETUP  2  clk cycles from ss_n low to the first spi_go
//  CS_HOLD   2  clk cycles from the last spi_done to ss_n high; also the minimum deselect gap
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-high
//  req_valid  in   NREQ       requester i asks for a burst; held until req_ready[i]
//  req_len    in   NREQ*LENW  slice i = words-1 of burst i; sampled at grant
//  req_ready  out  NREQ       one-cycle grant/accept pulse, one-hot
//  tx_data    in   NREQ*DW    slice i = next word to send for requester i
//  tx_valid   in   NREQ       tx_data slice valid
//  tx_ready   out  NREQ       word taken this cycle (valid&ready), owner only
//  rx_data    out  DW         word received from the core
//  rx_valid   out  NREQ       one-cycle pulse to owner, rx_data valid
//  xfer_done  out  NREQ       one-cycle pulse to owner when ss_n deasserts
//  ss_n       out  NREQ       per-requester slave select, active-low
//  busy       out  1          any burst in progress, incl. setup/hold
//  spi_go     out  1          to core go
//  spi_datai  out  DW         to core datai
//  spi_datao  in   DW         from core datao
//  spi_busy   in   1          from core busy
//  spi_done   in   1          from core done (one-cycle pulse)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge, also mid-burst): state IDLE, ss_n all 1, all pulses/spi_go/busy 0,
//   rx_data and spi_datai 0, RR pointer 0. No completion pulse for an aborted burst.
//  FSM: IDLE -> SETUP -> LOAD -> GO -> WAIT -> (LOAD | HOLD) -> IDLE.
//  IDLE: if any req_valid, grant per RR (start at ptr, ascending index mod NREQ);
//   req_ready[g]=1 that cycle, latch g and req_len, ptr<=g+1 mod NREQ, ss_n[g]<=0, count<=CS_SETUP.
//  SETUP: count down to 0 (the core keeps SCK idle).
//  LOAD: wait tx_valid[g]; on it tx_ready[g]=1, spi_datai<=tx_data slice g. Stall with ss_n low if idle.
//  GO: spi_go=1 held until spi_busy=1 is sampled, then WAIT with spi_go=0.
//  WAIT: on spi_done: rx_data<=spi_datao, rx_valid[g]=1 next cycle. If words left -> LOAD and decrement,
//   else HOLD with count<=CS_HOLD.
//  HOLD: count to 0, then ss_n[g]<=1, xfer_done[g]=1, and hold ss_n high for CS_HOLD cycles before IDLE.
//  Latency: req_valid to ss_n low = 1 cycle; CS_SETUP=0 goes to LOAD directly.
//  At most one ss_n bit low at any time; tx_ready/rx_valid/xfer_done only to the owner.
//  req_valid of others is ignored during a burst; its own req_valid dropping mid-burst is ignored.
//  A burst is never preempted.
//  Word counter is LENW bits; req_len=all-ones gives 2^LENW words, no wrap.
//  spi_done outside WAIT is ignored; busy=1 whenever state != IDLE.
// STRUCTURE
//  Shared package spi_sched_pkg: FSM state localparams, common counter widths.
//  Sub-module spi_rr_arbiter (NREQ): req vector + pointer -> one-hot grant + index, combinational.
//  Setup, hold and word counters plus the FSM stay in this module.
// TESTING (bench with spi_master + loopback slave model)
//  Single req0, len=0, tx=0xA5 -> one spi_go, ss_n[0] low, rx_valid[0] with 0xA5, one xfer_done[0].
//  req0 len=3, words 01..04 -> four go/done pairs, ss_n[0] low throughout, rx 01..04 in order.
//  req0+req1 together, repeated 4x -> grants alternate 0,1,0,1; never two ss_n low; gap >= CS_HOLD.
//  tx_valid withheld 50 cycles in LOAD -> spi_go stays 0, ss_n stays low, then resumes correctly.
//  rst pulse during WAIT of word 2 -> next cycle ss_n all 1, IDLE, no xfer_done; new burst works.
//  len=15 max -> exactly 16 words, counter does not wrap; stray spi_done in IDLE ignored.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// Shared types and widths for the SPI transfer scheduler.
// The FSM state encoding and the setup/hold counter width live here.
package spi_sched_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_GO,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } state_t;

endpackage

// File: rtl/spi_xfer_sched_if.sv
// Requester handshakes plus the spi_master core hookup for the transfer scheduler.
// The master modport is the scheduler side; the slave modport is the requesters and core.
interface spi_xfer_sched_if #(
    parameter int NREQ = 2,
    parameter int DW   = 8,
    parameter int LENW = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   tx_data;
    logic [NREQ-1:0]      tx_valid;
    logic [NREQ-1:0]      tx_ready;
    logic [DW-1:0]        rx_data;
    logic [NREQ-1:0]      rx_valid;
    logic [NREQ-1:0]      xfer_done;
    logic [NREQ-1:0]      ss_n;
    logic                 busy;
    logic                 spi_go;
    logic [DW-1:0]        spi_datai;
    logic [DW-1:0]        spi_datao;
    logic                 spi_busy;
    logic                 spi_done;

    modport master (
        input  req_valid, req_len, tx_data, tx_valid, spi_datao, spi_busy, spi_done,
        output req_ready, tx_ready, rx_data, rx_valid, xfer_done, ss_n, busy, spi_go, spi_datai
    );

    modport slave (
        output req_valid, req_len, tx_data, tx_valid, spi_datao, spi_busy, spi_done,
        input  req_ready, tx_ready, rx_data, rx_valid, xfer_done, ss_n, busy, spi_go, spi_datai
    );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
module spi_rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    found
);
    localparam int IW = $clog2(NREQ);

    // NOTE: every output gets a default before the loop so no path leaves a latch behind.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NREQ]) begin
                found                           = 1'b1;
                idx                             = IW'((int'(ptr) + k) % NREQ);
                grant[(int'(ptr) + k) % NREQ]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// Round-robin scheduler sharing one spi_master core between NREQ burst requesters.
// Owns the per-requester slave selects and streams each burst word by word through the core.
module spi_xfer_sched
    import spi_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int DW       = 8,
    parameter int LENW     = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input logic              clk,
    input logic              rst,
    spi_xfer_sched_if.master bus
);
    localparam int IW = $clog2(NREQ);

    state_t            state_q, state_d;
    logic [IW-1:0]     owner_q, ptr_q, gnt_idx;
    logic [NREQ-1:0]   gnt_vec;
    logic              gnt_found;
    logic [LENW-1:0]   words_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cnt_last;
    logic [NREQ-1:0]   ss_n_q, rx_valid_q, xfer_done_q;
    logic [DW-1:0]     rx_data_q, datai_q;
    logic              own_tx_valid;
    logic [DW-1:0]     own_tx_data;
    logic [NREQ-1:0]   req_ready_c, tx_ready_c;
    logic              spi_go_c, busy_c;

    spi_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr_q),
        .grant (gnt_vec),
        .idx   (gnt_idx),
        .found (gnt_found)
    );

    assign own_tx_valid = bus.tx_valid[owner_q];
    assign own_tx_data  = bus.tx_data[int'(owner_q)*DW +: DW];
    // Setup/hold/gap counters all finish on the cycle they hold 1 (or 0 when configured as 0).
    assign cnt_last     = (cnt_q <= CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (gnt_found)    state_d = (CS_SETUP == 0) ? ST_LOAD : ST_SETUP;
            ST_SETUP: if (cnt_last)     state_d = ST_LOAD;
            ST_LOAD:  if (own_tx_valid) state_d = ST_GO;
            ST_GO:    if (bus.spi_busy) state_d = ST_WAIT;
            ST_WAIT:  if (bus.spi_done) state_d = (words_q == '0) ? ST_HOLD : ST_LOAD;
            ST_HOLD:  if (cnt_last)     state_d = ST_GAP;
            ST_GAP:   if (cnt_last)     state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = '0;
        tx_ready_c  = '0;
        spi_go_c    = 1'b0;
        busy_c      = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: req_ready_c = gnt_vec;
            ST_LOAD: tx_ready_c[owner_q] = own_tx_valid;
            ST_GO:   spi_go_c = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= '0;
            ptr_q       <= '0;
            words_q     <= '0;
            cnt_q       <= '0;
            ss_n_q      <= '1;
            rx_valid_q  <= '0;
            xfer_done_q <= '0;
            rx_data_q   <= '0;
            datai_q     <= '0;
        end else begin
            rx_valid_q  <= '0;
            xfer_done_q <= '0;
            case (state_q)
                ST_IDLE: if (gnt_found) begin
                    owner_q <= gnt_idx;
                    ptr_q   <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IW'(1);
                    words_q <= bus.req_len[int'(gnt_idx)*LENW +: LENW];
                    ss_n_q  <= ~gnt_vec;
                    cnt_q   <= CNT_W'(CS_SETUP);
                end
                ST_SETUP: cnt_q <= cnt_q - CNT_W'(1);
                ST_LOAD:  if (own_tx_valid) datai_q <= own_tx_data;
                ST_WAIT: if (bus.spi_done) begin
                    rx_data_q           <= bus.spi_datao;
                    rx_valid_q[owner_q] <= 1'b1;
                    if (words_q == '0) cnt_q   <= CNT_W'(CS_HOLD);
                    else               words_q <= words_q - LENW'(1);
                end
                ST_HOLD: begin
                    if (cnt_last) begin
                        ss_n_q               <= '1;
                        xfer_done_q[owner_q] <= 1'b1;
                        cnt_q                <= CNT_W'(CS_HOLD);
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_GAP:  cnt_q <= cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.tx_ready  = tx_ready_c;
    assign bus.spi_go    = spi_go_c;
    assign bus.busy      = busy_c;
    assign bus.ss_n      = ss_n_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.xfer_done = xfer_done_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.spi_datai = datai_q;

endmodule
